// File: rtl/rgy_pkg.sv
// Shared RGY light encodings and pedestrian-state encoding for the traffic-light family.
// Pure declarations: no latency, no flow control.
package rgy_pkg;

  localparam logic [2:0] COLOR_RED    = 3'b100;
  localparam logic [2:0] COLOR_GREEN  = 3'b010;
  localparam logic [2:0] COLOR_YELLOW = 3'b001;

  typedef enum logic [1:0] {
    PED_DONT_WALK = 2'd0,
    PED_WALK      = 2'd1,
    PED_FLASH     = 2'd2
  } ped_state_e;

  function automatic logic color_legal(input logic [2:0] c);
    return (c == COLOR_RED) || (c == COLOR_GREEN) || (c == COLOR_YELLOW);
  endfunction

endpackage

// File: rtl/ped_signal_ctrl_if.sv
// Light-state input, push-button request and lamp/status outputs of the pedestrian controller.
// Wires only: no latency, no backpressure (all signals are level, sampled every clk).
interface ped_signal_ctrl_if;
  import rgy_pkg::*;

  logic [2:0] color;
  logic       ped_req;
  logic       walk;
  logic       dont_walk;
  logic       ped_wait;
  logic       abort;
  logic       fault;

  modport master (
    output color, ped_req,
    input  walk, dont_walk, ped_wait, abort, fault
  );

  modport slave (
    input  color, ped_req,
    output walk, dont_walk, ped_wait, abort, fault
  );

endinterface

// File: rtl/ped_flash_gen.sv
// DONT_WALK lamp flop with a half-period toggle counter; load forces a steady level.
// Output registered, one edge from load/en to level; no backpressure.
module ped_flash_gen #(
  parameter int HALF = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic load,
  input  logic load_val,
  output logic level
);
  import rgy_pkg::*;

  localparam int HW = (HALF > 1) ? $clog2(HALF) : 1;

  logic [HW-1:0] hcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt  <= '0;
      level <= 1'b1;
    end else if (load) begin
      hcnt  <= HW'(HALF - 1);
      level <= load_val;
    end else if (en) begin
      if (hcnt == '0) begin
        hcnt  <= HW'(HALF - 1);
        level <= ~level;
      end else begin
        hcnt <= hcnt - HW'(1);
      end
    end
  end

endmodule

// File: rtl/ped_signal_ctrl.sv
// Pedestrian WALK/DONT_WALK sequencer driven by the RGY light state; serves latched requests on red-rise.
// All outputs registered (visible right after the deciding edge); no backpressure.
module ped_signal_ctrl #(
  parameter int WALK_CYCLES  = 20,
  parameter int FLASH_CYCLES = 10,
  parameter int FLASH_HALF   = 1,
  parameter int CNT_W        = 8
) (
  input logic               clk,
  input logic               rst,
  ped_signal_ctrl_if.slave  bus
);
  import rgy_pkg::*;

  localparam logic [1:0] ST_DONT_WALK = PED_DONT_WALK;
  localparam logic [1:0] ST_WALK      = PED_WALK;
  localparam logic [1:0] ST_FLASH     = PED_FLASH;

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       prev_color;
  logic             ped_wait_q, ped_wait_nxt;
  logic             abort_q, abort_nxt;
  logic             fault_q, fault_nxt;
  logic             walk_q;
  logic             dont_walk_q;

  logic red_rise;
  logic in_phase;
  logic flash_en;

  assign red_rise = (bus.color == COLOR_RED) && (prev_color != COLOR_RED);
  assign in_phase = (state == ST_WALK) || (state == ST_FLASH);

  // Priority: illegal code, then leaving RED, then timer expiry.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    ped_wait_nxt = ped_wait_q;
    abort_nxt    = 1'b0;
    fault_nxt    = fault_q;
    if (!color_legal(bus.color)) begin
      fault_nxt = 1'b1;
      state_nxt = ST_DONT_WALK;
      cnt_nxt   = '0;
      abort_nxt = in_phase;
      if (state == ST_DONT_WALK)
        ped_wait_nxt = ped_wait_q | bus.ped_req;
    end else begin
      case (state)
        ST_WALK, ST_FLASH: begin
          if (bus.color != COLOR_RED) begin
            state_nxt = ST_DONT_WALK;
            cnt_nxt   = '0;
            abort_nxt = 1'b1;
          end else if (cnt == '0) begin
            state_nxt = (state == ST_WALK) ? ST_FLASH : ST_DONT_WALK;
            cnt_nxt   = (state == ST_WALK) ? CNT_W'(FLASH_CYCLES - 1) : '0;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        default: begin
          if (ped_wait_q && red_rise && !fault_q) begin
            state_nxt    = ST_WALK;
            cnt_nxt      = CNT_W'(WALK_CYCLES - 1);
            ped_wait_nxt = 1'b0;
          end else begin
            ped_wait_nxt = ped_wait_q | bus.ped_req;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_DONT_WALK;
      cnt        <= '0;
      prev_color <= 3'b000;
      ped_wait_q <= 1'b0;
      abort_q    <= 1'b0;
      fault_q    <= 1'b0;
      walk_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      prev_color <= bus.color;
      ped_wait_q <= ped_wait_nxt;
      abort_q    <= abort_nxt;
      fault_q    <= fault_nxt;
      walk_q     <= (state_nxt == ST_WALK);
    end
  end

  // The flash flop only free-runs while staying in FLASH; every other edge loads the steady level.
  assign flash_en = (state == ST_FLASH) && (state_nxt == ST_FLASH);

  ped_flash_gen #(
    .HALF(FLASH_HALF)
  ) u_flash (
    .clk      (clk),
    .rst      (rst),
    .en       (flash_en),
    .load     (!flash_en),
    .load_val (state_nxt != ST_WALK),
    .level    (dont_walk_q)
  );

  assign bus.walk      = walk_q;
  assign bus.dont_walk = dont_walk_q;
  assign bus.ped_wait  = ped_wait_q;
  assign bus.abort     = abort_q;
  assign bus.fault     = fault_q;

endmodule

// File: doc/ped_signal_ctrl.md
Name: ped_signal_ctrl

Overview:
- Downstream consumer of the RGY traffic-light controller's one-hot `color` output.
- Drives the pedestrian WALK / DONT_WALK lamps.
- Latches a pedestrian push-button request and serves it on the next entry into RED: steady WALK phase, then flashing DONT_WALK, then steady DONT_WALK.
- Also flags illegal light codes and premature exits from RED.

Parameters:
- WALK_CYCLES, 20, clock cycles of steady WALK (≥1).
- FLASH_CYCLES, 10, clock cycles of flashing DONT_WALK after WALK (≥1).
- FLASH_HALF, 1, cycles per half-period of the flash toggle (≥1).
- CNT_W, 8, counter width; must hold max(WALK_CYCLES, FLASH_CYCLES).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- color  input  3  light state from the traffic controller: 100=RED, 010=GREEN, 001=YELLOW.
- ped_req  input  1  push-button request, level or pulse, synchronous to clk.
- walk  output  1  WALK lamp.
- dont_walk  output  1  DONT_WALK lamp.
- ped_wait  output  1  a request is pending ("WAIT" indicator).
- abort  output  1  one-cycle pulse when a WALK/FLASH phase is cut short by leaving RED.
- fault  output  1  sticky: a non-one-hot color was seen.

Behaviour:
- Interface: one clock `clk`; reset `rst` is asynchronous and active-high. All outputs are registered.
- Reset values: state=DONT_WALK, walk=0, dont_walk=1, ped_wait=0, abort=0, fault=0, prev_color=000, counters=0.
- States:
  - DONT_WALK (walk=0, dont_walk=1).
  - WALK (walk=1, dont_walk=0).
  - FLASH (walk=0, dont_walk toggles).
- Red-rise: color==100 and prev_color!=100. prev_color is a register updated every cycle.
- Request latch:
  - ped_wait sets at the edge sampling ped_req=1 while in DONT_WALK.
  - It clears at the edge that enters WALK.
  - ped_req is ignored in WALK and FLASH.
  - ped_req=1 on the entry edge is absorbed, i.e. served.
- DONT_WALK→WALK: at the edge where ped_wait==1 and red-rise is sampled. walk=1 is visible right after that edge.
  - A request arriving mid-RED waits for the next red-rise; there is no late entry.
- WALK:
  - Counter loads WALK_CYCLES-1 on entry and decrements each cycle.
  - At 0 → FLASH, so walk is high for exactly WALK_CYCLES cycles.
- FLASH:
  - Lasts exactly FLASH_CYCLES cycles, then → DONT_WALK.
  - dont_walk starts at 1 and toggles every FLASH_HALF cycles.
  - Leaving FLASH forces dont_walk=1.
- Early exit: in WALK or FLASH, sampling color!=100 gives → DONT_WALK at that edge and abort=1 for one cycle. ped_wait stays 0.
- Fault:
  - Sampling color not in {100, 010, 001} sets fault, which stays set until rst.
  - It forces → DONT_WALK at that edge; abort pulses if the block was in WALK or FLASH.
  - While fault=1, the block remains in DONT_WALK. Requests still latch ped_wait but are never served.
- Invariants: walk and dont_walk are never both 1. Exactly one lamp is lit except during flash-off half-periods.
- Simultaneous events: fault takes priority over early exit, which takes priority over timer expiry.
- rst mid-phase returns immediately (asynchronously) to the reset values.

Decomposition:
- Shared package rgy_pkg:
  - Color constants COLOR_RED=3'b100, COLOR_GREEN=3'b010, COLOR_YELLOW=3'b001.
  - The ped-state enum.
- The traffic controller and its bench reuse the color constants.
- One natural sub-module: ped_flash_gen, the half-period counter plus toggle flop, with enable and load.

Test Plan (WALK_CYCLES=4, FLASH_CYCLES=6, FLASH_HALF=1):
- Nominal serve: color=GREEN, ped_req pulse → ped_wait=1; color→RED → walk=1 for 4 cycles, ped_wait=0. Then dont_walk toggles for 6 cycles, starting at 1 (pattern 1,0,1,0,1,0), then dont_walk=1 steady.
- No request: RED→GREEN→YELLOW→RED with ped_req=0 → walk stays 0, dont_walk stays 1 throughout.
- Mid-RED request: ped_req during RED → ped_wait=1, walk=0. At the next red-rise, walk=1 for 4 cycles.
- Early exit: walk active; color→GREEN on the 2nd walk cycle → next edge walk=0, dont_walk=1, abort=1 for exactly one cycle.
- Illegal code: color=3'b110 in any state → fault=1 and stays set; later red-rise with ped_wait=1 gives no walk. rst → fault=0.
- Async reset mid-FLASH: assert rst between clock edges → outputs take their reset values immediately, before the next clk edge.
